// File: rtl/cnu_serial_nms_array.sv
// -----------------------------------------------------------------------------
// cnu_serial_nms_array
//
// Z parallel check-node units running normalized min-sum with a run-time
// programmable degree (2..DEG_MAX). Edges arrive serially, one q message per
// lane per handshake. After the last edge, a single FINAL cycle scales the two
// running minima by ALPHA_NUM/4. The r messages then leave serially, one edge
// per output handshake.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start, cfg_deg    begin an update of degree cfg_deg (sampled in IDLE only)
//   abort             synchronous flush to IDLE from any busy state
//   in_valid/in_ready edge input handshake, in_q = Z lanes of W-bit q
//   out_valid/ready   edge output handshake, out_r = Z lanes of W-bit r
//   out_idx, out_last edge index of out_r, and a flag for edge deg-1
//   busy              FSM is not in IDLE
//   done              one-cycle pulse after the final output handshake
//   err_cfg           one-cycle pulse after a start with an illegal degree
// -----------------------------------------------------------------------------
module cnu_serial_nms_array #(
    parameter int Z         = 64,
    parameter int W         = 8,
    parameter int DEG_MAX   = 32,
    parameter int DEGW      = $clog2(DEG_MAX + 1),
    parameter int ALPHA_NUM = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DEGW-1:0]   cfg_deg,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [Z*W-1:0]    in_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [Z*W-1:0]    out_r,
    output logic [DEGW-1:0]   out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err_cfg
);

    localparam int MW = W - 1;
    localparam logic [MW-1:0] MAG_MAX = {MW{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FINAL, S_EMIT} state_t;

    state_t            state, state_nxt;
    logic [DEGW-1:0]   deg, k, j;
    logic              done_r, err_r;
    logic              start_ok, start_bad;
    logic              in_hs, out_hs, last_in, last_out;
    logic [DEG_MAX-1:0] onehot_k, onehot_j;

    // |q| limited to W-1 bits; the most negative code maps to the largest magnitude.
    function automatic logic [MW-1:0] sat_abs(input logic signed [W-1:0] v);
        logic [W-1:0] a;
        a = v[W-1] ? -v : v;
        return a[W-1] ? MAG_MAX : a[MW-1:0];
    endfunction

    // (m * ALPHA_NUM) >> 2 evaluated at W+2 bits; the result always fits in W-1 bits.
    function automatic logic [MW-1:0] scale(input logic [MW-1:0] m);
        logic [W+1:0] p;
        p = (W+2)'(m) * (W+2)'(ALPHA_NUM);
        return MW'(p >> 2);
    endfunction

    function automatic logic signed [W-1:0] apply_sign(input logic neg, input logic [MW-1:0] m);
        logic signed [W-1:0] v;
        v = signed'({1'b0, m});
        return neg ? -v : v;
    endfunction

    // Sign storage is addressed with a one-hot mask, so the index width never has to match DEG_MAX.
    assign onehot_k = DEG_MAX'(1) << k;
    assign onehot_j = DEG_MAX'(1) << j;

    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        in_hs     = (state == S_COLLECT) && in_valid;
        out_hs    = (state == S_EMIT) && out_ready;
        last_in   = in_hs && (k == deg - DEGW'(1));
        last_out  = out_hs && (j == deg - DEGW'(1));
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (cfg_deg >= DEGW'(2) && cfg_deg <= DEGW'(DEG_MAX)) begin
                        start_ok  = 1'b1;
                        state_nxt = S_COLLECT;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            S_COLLECT: if (last_in)  state_nxt = S_FINAL;
            S_FINAL:                 state_nxt = S_EMIT;
            S_EMIT:    if (last_out) state_nxt = S_IDLE;
            default:                 state_nxt = S_IDLE;
        endcase
        if (abort && state != S_IDLE) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deg    <= '0;
            k      <= '0;
            j      <= '0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            done_r <= last_out && !abort;
            err_r  <= start_bad;
            if (start_ok) begin
                deg <= cfg_deg;
                k   <= '0;
            end else if (in_hs) begin
                k <= k + DEGW'(1);
            end
            if (state == S_FINAL)  j <= '0;
            else if (out_hs)       j <= j + DEGW'(1);
        end
    end

    assign in_ready  = (state == S_COLLECT);
    assign out_valid = (state == S_EMIT);
    assign out_idx   = (state == S_EMIT) ? j : '0;
    assign out_last  = (state == S_EMIT) && (j == deg - DEGW'(1));
    assign busy      = (state != S_IDLE);
    assign done      = done_r;
    assign err_cfg   = err_r;

    for (genvar l = 0; l < Z; l++) begin : g_lane
        logic signed [W-1:0] q;
        logic [MW-1:0]       mag, min1, min2, s1, s2, m_sel;
        logic [DEGW-1:0]     idx;
        logic                sp, neg;
        logic [DEG_MAX-1:0]  sgn;

        assign q   = in_q[l*W +: W];
        assign mag = sat_abs(q);

        // Collect stage: running min1/min2/argmin and sign product; FINAL stage: scaling.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                min1 <= '0;
                min2 <= '0;
                idx  <= '0;
                sp   <= 1'b0;
                sgn  <= '0;
                s1   <= '0;
                s2   <= '0;
            end else begin
                if (start_ok) begin
                    min1 <= MAG_MAX;
                    min2 <= MAG_MAX;
                    idx  <= '0;
                    sp   <= 1'b0;
                end else if (in_hs) begin
                    sgn <= q[W-1] ? (sgn | onehot_k) : (sgn & ~onehot_k);
                    sp  <= sp ^ q[W-1];
                    // Strict compares keep the earliest edge as argmin on ties.
                    if (mag < min1) begin
                        min2 <= min1;
                        min1 <= mag;
                        idx  <= k;
                    end else if (mag < min2) begin
                        min2 <= mag;
                    end
                end
                if (state == S_FINAL) begin
                    s1 <= scale(min1);
                    s2 <= scale(min2);
                end
            end
        end

        // Emit stage: extrinsic magnitude and sign for edge j.
        always_comb begin
            m_sel = (j == idx) ? s2 : s1;
            neg   = sp ^ (|(sgn & onehot_j));
        end

        assign out_r[l*W +: W] = (state == S_EMIT) ? apply_sign(neg, m_sel) : '0;
    end

endmodule

// File: tb/tb_cnu_serial_nms_array.sv
module tb_cnu_serial_nms_array;

    localparam int Z = 64;
    localparam int W = 8;
    localparam int DEG_MAX = 32;
    localparam int DEGW = $clog2(DEG_MAX + 1);
    localparam int ALPHA_NUM = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [DEGW-1:0] cfg_deg;
    logic            abort;
    logic            in_valid;
    logic            in_ready;
    logic [Z*W-1:0]  in_q;
    logic            out_valid;
    logic            out_ready;
    logic [Z*W-1:0]  out_r;
    logic [DEGW-1:0] out_idx;
    logic            out_last;
    logic            busy;
    logic            done;
    logic            err_cfg;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int qv [DEG_MAX][Z];

    cnu_serial_nms_array #(
        .Z(Z), .W(W), .DEG_MAX(DEG_MAX), .DEGW(DEGW), .ALPHA_NUM(ALPHA_NUM)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_deg(cfg_deg), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_q(in_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done), .err_cfg(err_cfg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [Z*W-1:0] pack_edge(input int e);
        logic [Z*W-1:0] v;
        v = '0;
        for (int l = 0; l < Z; l++) v[l*W +: W] = 8'(qv[e][l]);
        return v;
    endfunction

    function automatic int mag_of(input int q);
        if (q == -128) return 127;
        return (q < 0) ? -q : q;
    endfunction

    // Reference: r_j = sign(prod of other signs) * alpha * min over the other edges' magnitudes.
    function automatic logic [Z*W-1:0] model_out(input int deg, input int j);
        logic [Z*W-1:0] v;
        int best, mn_other, m, val;
        bit sp, sg;
        v = '0;
        for (int l = 0; l < Z; l++) begin
            best = 0;
            sp = 0;
            for (int e = 0; e < deg; e++) begin
                if (mag_of(qv[e][l]) < mag_of(qv[best][l])) best = e;
                sp ^= (qv[e][l] < 0);
            end
            mn_other = 1000;
            for (int e = 0; e < deg; e++)
                if (e != best && mag_of(qv[e][l]) < mn_other) mn_other = mag_of(qv[e][l]);
            m = (j == best) ? mn_other : mag_of(qv[best][l]);
            m = (m * ALPHA_NUM) / 4;
            sg = sp ^ (qv[j][l] < 0);
            val = sg ? -m : m;
            v[l*W +: W] = 8'(val);
        end
        return v;
    endfunction

    task automatic fill_random(input int deg);
        for (int e = 0; e < deg; e++)
            for (int l = 0; l < Z; l++) qv[e][l] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic check_abort();
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_out_r", out_r, 0);
        @(posedge clk); #1;
        chk("abort_no_done", done, 0);
    endtask

    // bp: 0 ready high, 1 toggle 1010, 2 random. abort_ph: 1 in COLLECT at k=2, 2 in EMIT at j=1.
    task automatic do_update(input int deg, input int bp, input int abort_ph, input bit rst_mid, input bit gaps);
        int e, jx, guard, t_final;
        logic [Z*W-1:0] prev_r;
        logic [DEGW-1:0] prev_idx;
        bit stalled;
        start = 1'b1;
        cfg_deg = DEGW'(deg);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_start", busy, 1);
        e = 0;
        guard = 0;
        while (e < deg && guard < 8 * deg + 16) begin
            chk("in_ready_collect", in_ready, 1);
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_q = pack_edge(e);
            if (abort_ph == 1 && e == 2) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                in_valid = 1'b0;
                check_abort();
                return;
            end
            @(posedge clk); #1;
            if (in_valid) e++;
            guard++;
        end
        in_valid = 1'b0;
        if (e < deg) begin
            chk("collect_timeout", 0, 1);
            return;
        end
        t_final = cyc;
        chk("final_in_ready", in_ready, 0);
        chk("final_out_valid", out_valid, 0);
        chk("final_busy", busy, 1);
        @(posedge clk); #1;
        chk("first_out_valid", out_valid, 1);
        jx = 0;
        guard = 0;
        stalled = 0;
        prev_r = '0;
        prev_idx = '0;
        while (jx < deg && guard < 4 * deg + 16) begin
            if (bp == 0)      out_ready = 1'b1;
            else if (bp == 1) out_ready = (guard % 2 == 0);
            else              out_ready = 1'($urandom_range(0, 1));
            if (stalled) begin
                chk("stall_out_r", out_r, prev_r);
                chk("stall_out_idx", out_idx, prev_idx);
            end
            chk("out_valid", out_valid, 1);
            chk("out_idx", out_idx, jx);
            chk("out_last", out_last, (jx == deg - 1));
            chk("out_r", out_r, model_out(deg, jx));
            if (abort_ph == 2 && jx == 1) begin
                abort = 1'b1;
                out_ready = 1'b0;
                @(posedge clk); #1;
                abort = 1'b0;
                check_abort();
                return;
            end
            if (rst_mid && jx == 1) begin
                out_ready = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_r", out_r, 0);
                chk("rst_busy", busy, 0);
                chk("rst_out_idx", out_idx, 0);
                chk("rst_out_last", out_last, 0);
                #1 rst_n = 1'b1;
                @(posedge clk); #1;
                chk("rst_after_busy", busy, 0);
                return;
            end
            stalled = !out_ready;
            prev_r = out_r;
            prev_idx = out_idx;
            @(posedge clk); #1;
            if (out_ready) jx++;
            guard++;
        end
        out_ready = 1'b0;
        if (jx < deg) begin
            chk("emit_timeout", 0, 1);
            return;
        end
        chk("done", done, 1);
        chk("busy_after", busy, 0);
        if (bp == 0) chk("latency_final_to_done", cyc - t_final, deg + 1);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
    endtask

    task automatic cfg_err_test(input int d);
        int pulses;
        pulses = 0;
        start = 1'b1;
        cfg_deg = DEGW'(d);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulses += int'(err_cfg);
            chk("cfgerr_busy", busy, 0);
            chk("cfgerr_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        chk("cfgerr_pulses", pulses, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        cfg_deg = '0;
        abort = 1'b0;
        in_valid = 1'b0;
        in_q = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_r", out_r, 0);
        chk("reset_out_idx", out_idx, 0);
        chk("reset_out_last", out_last, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err_cfg", err_cfg, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // basic update, lane0 fixed
        fill_random(4);
        qv[0][0] = 5; qv[1][0] = -3; qv[2][0] = 7; qv[3][0] = -9;
        do_update(4, 0, 0, 0, 0);

        // ties and saturation
        fill_random(3);
        qv[0][0] = 4; qv[1][0] = 4; qv[2][0] = 6;
        qv[0][1] = -128; qv[1][1] = 5; qv[2][1] = -128;
        qv[0][2] = -128; qv[1][2] = -128; qv[2][2] = 127;
        do_update(3, 0, 0, 0, 1);

        // backpressure 1010
        fill_random(10);
        do_update(10, 1, 0, 0, 0);

        // configuration errors
        cfg_err_test(1);
        cfg_err_test(DEG_MAX + 1);
        cfg_err_test(0);

        // maximum degree
        fill_random(DEG_MAX);
        do_update(DEG_MAX, 2, 0, 0, 1);

        // abort in COLLECT, then a clean update
        fill_random(8);
        do_update(8, 0, 1, 0, 0);
        fill_random(5);
        do_update(5, 0, 0, 0, 0);

        // abort in EMIT, then a clean update
        fill_random(6);
        do_update(6, 1, 2, 0, 0);
        fill_random(7);
        do_update(7, 0, 0, 0, 0);

        // async reset in EMIT, then a clean update
        fill_random(6);
        do_update(6, 0, 0, 1, 0);
        fill_random(4);
        do_update(4, 0, 0, 0, 0);

        // random regression
        for (int t = 0; t < 20; t++) begin
            int d;
            d = int'($urandom_range(2, DEG_MAX));
            fill_random(d);
            do_update(d, int'($urandom_range(0, 2)), 0, 0, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
